mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-to-one memory bus arbiter between the core and the shared memory port. It takes the core's instruction-bus port (read-only) and data-bus port (read/write) and serialises them onto a single-beat downstream bus. It holds the granted request in registers until memory completes, then returns the response to the requester as a one-cycle `addr_ok`/`data_ok` pulse. Arbitration is round-robin when both ports request in the same cycle.

## Interface
Parameters:
- `ADDR_W`, default 64: address width on all ports.
- `DATA_W`, default 64: downstream data width; a data-port transfer is at most one 8-byte word.

Ports (name, direction, width, meaning):
- `clk` in 1: clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `i_valid` in 1: instruction fetch request; held high until `i_data_ok`.
- `i_addr` in ADDR_W: fetch address, 4-byte aligned.
- `i_addr_ok` out 1: request accepted; pulses in the same cycle as `i_data_ok`.
- `i_data_ok` out 1: response valid, one-cycle pulse.
- `i_rdata` out 32: fetched instruction.
- `d_valid` in 1: data request; held high until `d_data_ok`.
- `d_addr` in ADDR_W: data address.
- `d_size` in 3: log2 of the byte count (0 to 3).
- `d_strobe` in 8: byte write enables; all-zero means a read.
- `d_wdata` in DATA_W: write data, already lane-aligned.
- `d_addr_ok` out 1: request accepted; pulses in the same cycle as `d_data_ok`.
- `d_data_ok` out 1: response valid, one-cycle pulse.
- `d_rdata` out DATA_W: full 8-byte word of read data.
- `m_valid` out 1: downstream request valid.
- `m_is_write` out 1: 1 means a write.
- `m_addr` out ADDR_W: downstream address.
- `m_size` out 3: downstream size.
- `m_strobe` out 8: downstream byte enables.
- `m_wdata` out DATA_W: downstream write data.
- `m_ready` in 1: memory completes the transaction this cycle; `m_rdata` is valid with it.
- `m_rdata` in DATA_W: downstream read data.

## Operation
State machine with five states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.

- **IDLE**
  - Sample `i_valid` and `d_valid`.
  - Only one valid: grant that port.
  - Both valid: grant the port not granted last. The `last_grant` flop resets to I, so D wins the first tie.
  - On grant: latch the address and, for D, size/strobe/wdata into request registers. Update `last_grant`. Go to BUSY_x.
  - No valid: stay in IDLE.
- **BUSY_I**
  - Drive `m_valid`=1, `m_is_write`=0, `m_addr`=latched address, `m_size`=3'b010, `m_strobe`=0.
- **BUSY_D**
  - Drive `m_valid`=1, `m_is_write`=(latched strobe != 0), and the latched addr/size/strobe/wdata.
- **BUSY_x exit**
  - On `m_ready`: capture `m_rdata` into the response register and go to DONE_x.
  - Without `m_ready`: hold the request stable indefinitely.
- **DONE_I**
  - Pulse `i_addr_ok`=`i_data_ok`=1.
  - `i_rdata` = latched addr[2] ? resp[63:32] : resp[31:0].
  - Next state: IDLE.
- **DONE_D**
  - Pulse `d_addr_ok`=`d_data_ok`=1 with `d_rdata`=resp.
  - Next state: IDLE.
- **Response data hold**
  - `i_rdata` and `d_rdata` keep their last value outside DONE states.
  - For a write, `d_rdata` is don't-care.
- **Boundary conditions**
  - Requests are never pre-empted. A port arriving during BUSY or DONE waits until IDLE.
  - A requester dropping valid mid-transaction does not abort it: the memory transaction completes and the data_ok pulse still fires.
  - Only one upstream port sees ok in any cycle.
  - `m_valid` is never asserted in IDLE or DONE states.
- **Reset** (asynchronous, immediate)
  - State goes to IDLE and `last_grant` to I.
  - All outputs go to 0, including `i_rdata`, `d_rdata`, `m_addr`, `m_wdata` and the response register.
  - Reset mid-BUSY abandons the downstream transaction; memory must tolerate `m_valid` falling without `m_ready`.

## Timing
- Request at cycle T, memory ready on first beat:
  - T+1: `m_valid`=1 and `m_ready`=1.
  - T+2: `data_ok`.
  - T+3: back in IDLE.
- Minimum upstream latency is 2 cycles. Each extra memory wait cycle adds 1.
- Back-to-back requests from the same port are spaced at least 3 cycles apart. After `data_ok`, a new grant happens in the next IDLE cycle.
- All outputs are registered-state decodes; there is no combinational path from `i_valid`/`d_valid` to `m_*`.
- `m_*` outputs are stable for the whole BUSY period.

## Test plan
- **Single fetch:** `i_valid`=1, `i_addr`=0x8000_0004; memory returns 0x1111_2222_3333_4444 with `m_ready` in the first BUSY cycle → `m_addr`=0x8000_0004, `m_is_write`=0; two cycles after the request, `i_data_ok` pulses once with `i_rdata`=0x1111_2222.
- **Store with wait states:** `d_valid`, `d_addr`=0x8000_1000, `d_strobe`=0x0F, `d_wdata`=0xDEAD_BEEF; `m_ready` delayed 4 cycles → `m_is_write`=1, fields stable for 5 cycles, then `d_data_ok` one cycle after `m_ready`.
- **Simultaneous requests from reset:** both valid at once → D is served first, then I. Repeat with both continuously valid → grants alternate D, I, D, I.
- **Late arrival:** I arrives while D is in BUSY → `m_addr` remains D's address; I is granted in the IDLE cycle after `d_data_ok`.
- **Reset mid-BUSY:** assert `reset` mid-BUSY_D → `m_valid` falls in the same cycle, no `data_ok` fires, all outputs read 0. After release, a new I request is served normally.
- **Withdrawn request:** `d_valid` dropped mid-BUSY → the memory transaction still completes and `d_data_ok` still pulses once.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin 2:1 arbiter serialising instruction and data ports onto one single-beat memory bus
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [31:0]       i_rdata,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_size,
    input  logic [7:0]        d_strobe,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_valid,
    output logic              m_is_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_size,
    output logic [7:0]        m_strobe,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata
);
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

    state_t state;
    logic   last_d;

    assign i_addr_ok = i_data_ok;
    assign d_addr_ok = d_data_ok;

    // m_* registers double as the latched request, so they stay stable through BUSY
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_d     <= 1'b0;
            i_data_ok  <= 1'b0;
            d_data_ok  <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            m_valid    <= 1'b0;
            m_is_write <= 1'b0;
            m_addr     <= '0;
            m_size     <= '0;
            m_strobe   <= '0;
            m_wdata    <= '0;
        end else begin
            i_data_ok <= 1'b0;
            d_data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_valid && (!i_valid || !last_d)) begin
                        state      <= BUSY_D;
                        last_d     <= 1'b1;
                        m_valid    <= 1'b1;
                        m_is_write <= |d_strobe;
                        m_addr     <= d_addr;
                        m_size     <= d_size;
                        m_strobe   <= d_strobe;
                        m_wdata    <= d_wdata;
                    end else if (i_valid) begin
                        state      <= BUSY_I;
                        last_d     <= 1'b0;
                        m_valid    <= 1'b1;
                        m_is_write <= 1'b0;
                        m_addr     <= i_addr;
                        m_size     <= 3'b010;
                        m_strobe   <= 8'h00;
                    end
                end
                BUSY_I: begin
                    if (m_ready) begin
                        state     <= DONE_I;
                        m_valid   <= 1'b0;
                        i_data_ok <= 1'b1;
                        i_rdata   <= m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
                    end
                end
                BUSY_D: begin
                    if (m_ready) begin
                        state     <= DONE_D;
                        m_valid   <= 1'b0;
                        d_data_ok <= 1'b1;
                        d_rdata   <= m_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions checked against a transaction-level model
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [63:0] i_addr = '0;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_rdata;
    logic        d_valid = 1'b0;
    logic [63:0] d_addr = '0;
    logic [2:0]  d_size = '0;
    logic [7:0]  d_strobe = '0;
    logic [63:0] d_wdata = '0;
    logic        d_addr_ok, d_data_ok;
    logic [63:0] d_rdata;
    logic        m_valid, m_is_write;
    logic [63:0] m_addr;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    logic [63:0] m_wdata;
    logic        m_ready = 1'b0;
    logic [63:0] m_rdata = '0;

    int vectors = 0;
    int miscompares = 0;
    bit last_was_d = 1'b0;
    logic [31:0] exp_i_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_is_write(m_is_write), .m_addr(m_addr), .m_size(m_size),
        .m_strobe(m_strobe), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " m_valid"}, m_valid, 0);
        chk({tag, " m_addr"}, m_addr, 0);
        chk({tag, " m_wdata"}, m_wdata, 0);
        chk({tag, " m_is_write"}, m_is_write, 0);
        chk({tag, " m_strobe"}, m_strobe, 0);
        chk({tag, " oks"}, {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
        chk({tag, " i_rdata"}, i_rdata, 0);
        chk({tag, " d_rdata"}, d_rdata, 0);
    endtask

    task automatic new_i(input logic [63:0] a);
        i_valid = 1'b1;
        i_addr = a & ~64'h3;
    endtask

    task automatic new_d(input logic [63:0] a, input logic [7:0] st, input logic [63:0] wd, input logic [2:0] sz);
        d_valid = 1'b1;
        d_addr = a;
        d_strobe = st;
        d_wdata = wd;
        d_size = sz;
    endtask

    task automatic rnd_i();
        new_i({$urandom, $urandom});
    endtask

    task automatic rnd_d();
        new_d({$urandom, $urandom}, ($urandom % 2) ? 8'($urandom) : 8'h00, {$urandom, $urandom}, 3'($urandom_range(0, 3)));
    endtask

    // One complete transaction from IDLE: grant, w wait cycles, ready, DONE pulse, back to IDLE.
    task automatic txn(input int w, input bit drop, input bit raise, input logic [63:0] rd);
        bit gd;
        logic [63:0] ea, ewd;
        logic [2:0] es;
        logic [7:0] est;
        logic ew;
        gd = d_valid && (!i_valid || !last_was_d);
        last_was_d = gd;
        ea  = gd ? d_addr : i_addr;
        es  = gd ? d_size : 3'b010;
        est = gd ? d_strobe : 8'h00;
        ew  = gd && (d_strobe != 0);
        ewd = d_wdata;
        step();
        for (int k = 0; k <= w; k++) begin
            chk("busy m_valid", m_valid, 1);
            chk("busy m_addr", m_addr, ea);
            chk("busy m_is_write", m_is_write, ew);
            chk("busy m_size", m_size, es);
            chk("busy m_strobe", m_strobe, est);
            if (gd) chk("busy m_wdata", m_wdata, ewd);
            chk("busy oks", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
            if (k == w) begin
                m_ready = 1'b1;
                m_rdata = rd;
            end else begin
                if (drop && k == 0) begin
                    if (gd) d_valid = 1'b0; else i_valid = 1'b0;
                end
                if (raise && gd && !i_valid) rnd_i();
                if (raise && !gd && !d_valid) rnd_d();
            end
            step();
        end
        m_ready = 1'b0;
        m_rdata = {$urandom, $urandom};
        chk("done m_valid", m_valid, 0);
        if (gd) begin
            chk("done d oks", {d_addr_ok, d_data_ok}, 2'b11);
            chk("done i oks", {i_addr_ok, i_data_ok}, 0);
            if (!ew) chk("done d_rdata", d_rdata, rd);
            chk("hold i_rdata", i_rdata, exp_i_rdata);
            d_valid = 1'b0;
        end else begin
            exp_i_rdata = ea[2] ? rd[63:32] : rd[31:0];
            chk("done i oks", {i_addr_ok, i_data_ok}, 2'b11);
            chk("done d oks", {d_addr_ok, d_data_ok}, 0);
            chk("done i_rdata", i_rdata, exp_i_rdata);
            i_valid = 1'b0;
        end
        step();
        chk("idle m_valid", m_valid, 0);
        chk("idle oks", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_valid = 1'b0;
        d_valid = 1'b0;
        step();
        chk_all_zero("reset");
        reset = 1'b0;
        last_was_d = 1'b0;
        exp_i_rdata = '0;
    endtask

    initial begin
        do_reset();

        // single fetch
        new_i(64'h8000_0004);
        txn(0, 0, 0, 64'h1111_2222_3333_4444);
        chk("fetch i_rdata", i_rdata, 64'h1111_2222);

        // store with wait states
        new_d(64'h8000_1000, 8'h0F, 64'hDEAD_BEEF, 3'd2);
        txn(4, 0, 0, 64'h5555_6666_7777_8888);

        // simultaneous requests from reset: D then I, then alternating
        do_reset();
        new_i(64'h1000);
        new_d(64'h2000, 8'h00, 64'h0, 3'd3);
        txn(0, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("tie second owner is I", i_valid, 1);
        new_d(64'h3000, 8'hFF, 64'h0123_4567_89AB_CDEF, 3'd3);
        txn(1, 0, 0, 64'h0102_0304_0506_0708);
        chk("tie I rdata", i_rdata, 64'h0506_0708);
        new_i(64'h4004);
        txn(0, 0, 0, 64'h9);
        txn(2, 0, 0, 64'hFEED_FACE_0000_0000);
        chk("alt I rdata", i_rdata, 64'hFEED_FACE);

        // late arrival: I raised while D is busy
        new_d(64'h8000_2000, 8'h00, 64'h0, 3'd3);
        txn(3, 0, 1, 64'h1234_5678_9ABC_DEF0);
        chk("late I pending", i_valid, 1);
        txn(0, 0, 0, 64'h0);

        // reset mid-BUSY_D
        new_d(64'h8000_3000, 8'hF0, 64'hCAFE_0000_0000_0000, 3'd2);
        step();
        chk("pre-reset m_valid", m_valid, 1);
        #1 reset = 1'b1;
        #1 chk_all_zero("async reset");
        d_valid = 1'b0;
        step();
        reset = 1'b0;
        last_was_d = 1'b0;
        exp_i_rdata = '0;
        step();
        chk("post-reset oks", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
        chk("post-reset m_valid", m_valid, 0);
        new_i(64'h8000_0000);
        txn(1, 0, 0, 64'h7777_0000_4242_4242);
        chk("post-reset I rdata", i_rdata, 64'h4242_4242);

        // withdrawn request
        new_d(64'h8000_4000, 8'h00, 64'h0, 3'd3);
        txn(3, 1, 0, 64'h0BAD_F00D_0BAD_F00D);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            if (!i_valid && ($urandom % 2)) rnd_i();
            if (!d_valid && ($urandom % 2)) rnd_d();
            if (!i_valid && !d_valid) begin
                step();
                chk("rand idle m_valid", m_valid, 0);
                chk("rand idle oks", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
            end else begin
                txn(int'($urandom_range(0, 3)), ($urandom % 4) == 0, bit'($urandom % 2), {$urandom, $urandom});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
